// File: rtl/wb_stage_regfile_pkg.sv
// Shared types and constants for the writeback stage of the 8-bit core.
package wb_stage_regfile_pkg;

  localparam int unsigned DATA_W                = 8;
  localparam int unsigned REG_ADDR_W            = 3;
  localparam int unsigned NUM_REGS              = 1 << REG_ADDR_W;
  localparam int unsigned SQUASH_DEPTH_DEFAULT  = 2;
  localparam int unsigned RETIRE_W_DEFAULT      = 16;

  typedef logic [1:0] opcode_t;

  // EX/WB pipeline register contents as seen by the writeback stage.
  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     imm;
    logic                  branch;
    logic                  reg_write;
    logic                  imm_to_reg;
    logic [REG_ADDR_W-1:0] rd;
    opcode_t               opcode;
  } ex_wb_t;

endpackage

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// Architectural register file: one write port, two combinational read ports with
// same-cycle write bypass. Build with WB_ZERO_REG_EN to hard-wire register 0 to zero.
module wb_stage_regfile_regfile_2r1w
  import wb_stage_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o,
  output logic                  we_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              we_eff;

  // Effective write enable; r0 writes are dropped when it is hard-wired.
  always_comb begin
`ifdef WB_ZERO_REG_EN
    we_eff = we_i && (waddr_i != '0);
`else
    we_eff = we_i;
`endif
  end

  assign we_o = we_eff;

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_eff) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: bypass the in-flight write so decode sees it in the same cycle.
  always_comb begin
    rdata1_o = (we_eff && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
    rdata2_o = (we_eff && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
`ifdef WB_ZERO_REG_EN
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
`endif
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: write-data select, register file, registered branch redirect/flush,
// wrong-path squash window and retire counter. Optional macro: WB_ZERO_REG_EN (r0 reads 0).
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = SQUASH_DEPTH_DEFAULT,
  parameter int unsigned RETIRE_W     = RETIRE_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pc_EX_WB,
  input  logic [DATA_W-1:0]     aluResult_EX_WB,
  input  logic [DATA_W-1:0]     immOut_EX_WB,
  input  logic                  branch_EX_WB,
  input  logic                  regWrite_EX_WB,
  input  logic                  immToReg_EX_WB,
  input  logic [REG_ADDR_W-1:0] rd_EX_WB,
  input  opcode_t               opcode_EX_WB,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_we,
  output logic                  redirect_valid,
  output logic [DATA_W-1:0]     redirect_pc,
  output logic                  flush,
  output logic [RETIRE_W-1:0]   retire_count
);

  localparam int unsigned SqW = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

  ex_wb_t ex_wb;
  assign ex_wb = '{
    pc:         pc_EX_WB,
    alu:        aluResult_EX_WB,
    imm:        immOut_EX_WB,
    branch:     branch_EX_WB,
    reg_write:  regWrite_EX_WB,
    imm_to_reg: immToReg_EX_WB,
    rd:         rd_EX_WB,
    opcode:     opcode_EX_WB
  };

  // Opcode travels with the bundle but has no effect in WB.
  logic unused_opcode;
  assign unused_opcode = ^ex_wb.opcode;

  logic                redirect_valid_q, flush_q;
  logic [DATA_W-1:0]   redirect_pc_q;
  logic [SqW-1:0]      squash_cnt_q, squash_cnt_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                squash_active, br_take, req_we;
  logic [DATA_W-1:0]   target;

  // Wrong-path suppression and branch target (8-bit wraparound add).
  always_comb begin
    squash_active = (squash_cnt_q != '0);
    br_take       = ex_wb.branch && !squash_active;
    req_we        = ex_wb.reg_write && !squash_active;
    wb_data       = ex_wb.imm_to_reg ? ex_wb.imm : ex_wb.alu;
    target        = ex_wb.pc + ex_wb.imm;
  end

  wb_stage_regfile_regfile_2r1w u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (req_we),
    .waddr_i  (ex_wb.rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_o     (wb_we)
  );

  // Next squash count and retire count; a squashed branch never reloads the window.
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (br_take) begin
      squash_cnt_d = SqW'(SQUASH_DEPTH);
    end else if (squash_active) begin
      squash_cnt_d = squash_cnt_q - SqW'(1);
    end
    retire_d = retire_q;
    if ((ex_wb.reg_write || ex_wb.branch) && !squash_active) begin
      retire_d = retire_q + RETIRE_W'(1);
    end
  end

  // Redirect/flush pulses, redirect target, squash window and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      squash_cnt_q     <= '0;
      retire_q         <= '0;
    end else begin
      redirect_valid_q <= br_take;
      flush_q          <= br_take;
      if (br_take) begin
        redirect_pc_q <= target;
      end
      squash_cnt_q <= squash_cnt_d;
      retire_q     <= retire_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed table-driven bench for wb_stage_regfile plus hand-written reset/squash sequences.
module tb_wb_stage_regfile;
  import wb_stage_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc, alu, imm;
  logic        br, rw, i2r;
  logic [2:0]  rd, a1, a2;
  opcode_t     opc;
  logic [7:0]  rs1_data, rs2_data, wb_data, redirect_pc;
  logic        wb_we, redirect_valid, flush;
  logic [15:0] retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .pc_EX_WB        (pc),
    .aluResult_EX_WB (alu),
    .immOut_EX_WB    (imm),
    .branch_EX_WB    (br),
    .regWrite_EX_WB  (rw),
    .immToReg_EX_WB  (i2r),
    .rd_EX_WB        (rd),
    .opcode_EX_WB    (opc),
    .rs1_addr        (a1),
    .rs2_addr        (a2),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .wb_data         (wb_data),
    .wb_we           (wb_we),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .retire_count    (retire_count)
  );

  typedef struct {
    logic        rw, i2r, br;
    logic [7:0]  pc, alu, imm;
    logic [2:0]  rd, a1, a2;
    logic [7:0]  e1, e2;
    logic        ewe, erv, efl;
    logic [7:0]  erpc;
    logic [15:0] eret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rw_v, i2r_v, br_v,
                              input logic [7:0] pc_v, alu_v, imm_v,
                              input logic [2:0] rd_v, a1_v, a2_v,
                              input logic [7:0] e1_v, e2_v,
                              input logic ewe_v, erv_v, efl_v,
                              input logic [7:0] erpc_v, input logic [15:0] eret_v);
    vec_t v;
    v.rw = rw_v; v.i2r = i2r_v; v.br = br_v;
    v.pc = pc_v; v.alu = alu_v; v.imm = imm_v;
    v.rd = rd_v; v.a1 = a1_v; v.a2 = a2_v;
    v.e1 = e1_v; v.e2 = e2_v; v.ewe = ewe_v; v.erv = erv_v; v.efl = efl_v;
    v.erpc = erpc_v; v.eret = eret_v;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rw = v.rw; i2r = v.i2r; br = v.br;
    pc = v.pc; alu = v.alu; imm = v.imm;
    rd = v.rd; a1 = v.a1; a2 = v.a2;
    opc = 2'b01;
  endtask

  // Drive at negedge, check combinational outputs before the edge, registered after it.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [7:0] exp_wd;
    @(negedge clk);
    drive(v);
    #2;
    exp_wd = v.i2r ? v.imm : v.alu;
    chk({tag, " rs1_data"}, {8'h00, rs1_data}, {8'h00, v.e1});
    chk({tag, " rs2_data"}, {8'h00, rs2_data}, {8'h00, v.e2});
    chk({tag, " wb_we"}, {15'h0, wb_we}, {15'h0, v.ewe});
    chk({tag, " wb_data"}, {8'h00, wb_data}, {8'h00, exp_wd});
    @(posedge clk);
    #1;
    chk({tag, " redirect_valid"}, {15'h0, redirect_valid}, {15'h0, v.erv});
    chk({tag, " flush"}, {15'h0, flush}, {15'h0, v.efl});
    chk({tag, " redirect_pc"}, {8'h00, redirect_pc}, {8'h00, v.erpc});
    chk({tag, " retire_count"}, retire_count, v.eret);
  endtask

  initial begin
    // rw i2r br  pc     alu    imm    rd    a1    a2    e1     e2     we rv fl rpc    ret
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h5A, 3'd3, 3'd3, 3'd0, 8'h5A, 8'h00, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd3, 3'd3, 8'h5A, 8'h5A, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h33, 8'h00, 3'd5, 3'd5, 3'd5, 8'h33, 8'h33, 1, 0, 0, 8'h00, 2));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd5, 3'd3, 8'h33, 8'h5A, 0, 0, 0, 8'h00, 2));
    // Taken branch with wrapping target, then two squashed writes.
    vecs.push_back(mk(0, 0, 1, 8'hF0, 8'h00, 8'h20, 3'd0, 3'd5, 3'd3, 8'h33, 8'h5A, 0, 1, 1, 8'h10, 3));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h11, 3'd1, 3'd1, 3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h10, 3));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h22, 3'd2, 3'd1, 3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h10, 3));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h10, 3));
    // Branch, branch inside the window (ignored), squashed write, then a committed write.
    vecs.push_back(mk(0, 0, 1, 8'h10, 8'h00, 8'h05, 3'd0, 3'd5, 3'd3, 8'h33, 8'h5A, 0, 1, 1, 8'h15, 4));
    vecs.push_back(mk(0, 0, 1, 8'h40, 8'h00, 8'h40, 3'd0, 3'd5, 3'd3, 8'h33, 8'h5A, 0, 0, 0, 8'h15, 4));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h44, 3'd4, 3'd4, 3'd0, 8'h00, 8'h00, 0, 0, 0, 8'h15, 4));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h66, 3'd6, 3'd6, 3'd4, 8'h66, 8'h00, 1, 0, 0, 8'h15, 5));
    // Branch that also writes rd.
    vecs.push_back(mk(1, 0, 1, 8'h80, 8'h99, 8'hFE, 3'd7, 3'd7, 3'd6, 8'h99, 8'h66, 1, 1, 1, 8'h7E, 6));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h12, 3'd1, 3'd7, 3'd1, 8'h99, 8'h00, 0, 0, 0, 8'h7E, 6));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd1, 3'd7, 8'h00, 8'h99, 0, 0, 0, 8'h7E, 6));
    // Write to r0.
`ifdef WB_ZERO_REG_EN
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h77, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0, 0, 8'h7E, 7));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd7, 8'h00, 8'h99, 0, 0, 0, 8'h7E, 7));
`else
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 8'h77, 3'd0, 3'd0, 3'd0, 8'h77, 8'h77, 1, 0, 0, 8'h7E, 7));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd7, 8'h77, 8'h99, 0, 0, 0, 8'h7E, 7));
`endif

    // Reset state.
    rst = 1'b0;
    drive(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd3, 3'd5, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    #2;
    chk("reset redirect_valid", {15'h0, redirect_valid}, 16'h0);
    chk("reset flush", {15'h0, flush}, 16'h0);
    chk("reset redirect_pc", {8'h00, redirect_pc}, 16'h0);
    chk("reset retire_count", retire_count, 16'h0);
    chk("reset rs1_data", {8'h00, rs1_data}, 16'h0);
    chk("reset rs2_data", {8'h00, rs2_data}, 16'h0);
    #5 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Open a squash window, let it count down to 1, then reset asynchronously.
    apply_vec(mk(0, 0, 1, 8'h00, 8'h00, 8'h08, 3'd0, 3'd1, 3'd2, 8'h00, 8'h00, 0, 1, 1, 8'h08, 8),
              "seq_br");
    apply_vec(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd7, 3'd6, 8'h99, 8'h66, 0, 0, 0, 8'h08, 8),
              "seq_sq");
    @(negedge clk);
    drive(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd7, 3'd4, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
    rst = 1'b0;
    #1;
    chk("arst redirect_valid", {15'h0, redirect_valid}, 16'h0);
    chk("arst flush", {15'h0, flush}, 16'h0);
    chk("arst redirect_pc", {8'h00, redirect_pc}, 16'h0);
    chk("arst retire_count", retire_count, 16'h0);
    chk("arst rs1_data", {8'h00, rs1_data}, 16'h0);
    chk("arst rs2_data", {8'h00, rs2_data}, 16'h0);
    #1 rst = 1'b1;
    // Squash window was aborted, so this write commits.
    apply_vec(mk(1, 1, 0, 8'h00, 8'h00, 8'hAB, 3'd2, 3'd2, 3'd7, 8'hAB, 8'h00, 1, 0, 0, 8'h00, 1),
              "post_rst_wr");
    apply_vec(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd2, 3'd6, 8'hAB, 8'h00, 0, 0, 0, 8'h00, 1),
              "post_rst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
